// File: rtl/super_writeback.sv
// Writeback stage: commits ALU results to the integer/vector register files in
// one cycle, and assembles little-endian load beats into full words before committing them.
module super_writeback #(
  parameter int REGI_BITS = 4,
  parameter int VECT_BITS = 2,
  parameter int REGI_SIZE = 16,
  parameter int VECT_SIZE = 8,
  parameter int ELEM_SIZE = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic                          writeResultInt_i,
  input  logic                          writeResultV_i,
  input  logic                          flagMemRead_i,
  input  logic [REGI_BITS-1:0]          int_dest_i,
  input  logic [VECT_BITS-1:0]          vec_dest_i,
  input  logic [REGI_SIZE-1:0]          int_result_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] vec_result_i,
  input  logic                          mem_valid_i,
  input  logic [ELEM_SIZE-1:0]          mem_data_i,
  output logic                          int_we_o,
  output logic [REGI_BITS-1:0]          int_dest_o,
  output logic [REGI_SIZE-1:0]          int_wd_o,
  output logic                          vec_we_o,
  output logic [VECT_BITS-1:0]          vec_dest_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] vec_wd_o,
  output logic                          stall_o
);

  localparam int VEC_W     = ELEM_SIZE * VECT_SIZE;
  localparam int INT_BEATS = REGI_SIZE / ELEM_SIZE;
  localparam int MAX_BEATS = (VECT_SIZE > INT_BEATS) ? VECT_SIZE : INT_BEATS;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       beats_r;
  logic                   tgt_vec_r;
  logic [REGI_BITS-1:0]   int_dest_r;
  logic [VECT_BITS-1:0]   vec_dest_r;
  logic [VEC_W-1:0]       buf_r;

  logic [CNT_W-1:0]       load_beats_s;
  logic [VEC_W-1:0]       asm_s;
  logic                   last_beat_s;

  // Beat count for a new load, current assembly word and last-beat detect.
  always_comb begin
    load_beats_s = {CNT_W{1'b0}};
    if (writeResultV_i) begin
      load_beats_s = CNT_W'(VECT_SIZE);
    end else if (writeResultInt_i) begin
      load_beats_s = CNT_W'(INT_BEATS);
    end else begin
      load_beats_s = {CNT_W{1'b0}};
    end
    asm_s = buf_r;
    asm_s[int'(cnt_r)*ELEM_SIZE +: ELEM_SIZE] = mem_data_i;
    last_beat_s = mem_valid_i && (cnt_r == (beats_r - CNT_W'(1)));
  end

  // Control FSM with registered write ports and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      beats_r    <= {CNT_W{1'b0}};
      tgt_vec_r  <= 1'b0;
      int_dest_r <= {REGI_BITS{1'b0}};
      vec_dest_r <= {VECT_BITS{1'b0}};
      buf_r      <= {VEC_W{1'b0}};
      ready_o    <= 1'b1;
      stall_o    <= 1'b0;
      int_we_o   <= 1'b0;
      int_dest_o <= {REGI_BITS{1'b0}};
      int_wd_o   <= {REGI_SIZE{1'b0}};
      vec_we_o   <= 1'b0;
      vec_dest_o <= {VECT_BITS{1'b0}};
      vec_wd_o   <= {VEC_W{1'b0}};
    end else begin
      int_we_o <= 1'b0;
      vec_we_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (valid_i && ready_o) begin
            if (flagMemRead_i) begin
              tgt_vec_r  <= writeResultV_i;
              int_dest_r <= int_dest_i;
              vec_dest_r <= vec_dest_i;
              cnt_r      <= {CNT_W{1'b0}};
              beats_r    <= load_beats_s;
              ready_o    <= 1'b0;
              stall_o    <= 1'b1;
              // A load with no target still takes the COMMIT slot, just without a write.
              if (load_beats_s == {CNT_W{1'b0}}) begin
                state_r <= COMMIT;
              end else begin
                state_r <= COLLECT;
              end
            end else begin
              int_we_o <= writeResultInt_i;
              vec_we_o <= writeResultV_i;
              if (writeResultInt_i) begin
                int_dest_o <= int_dest_i;
                int_wd_o   <= int_result_i;
              end
              if (writeResultV_i) begin
                vec_dest_o <= vec_dest_i;
                vec_wd_o   <= vec_result_i;
              end
            end
          end
        end
        COLLECT: begin
          if (mem_valid_i) begin
            buf_r <= asm_s;
            cnt_r <= cnt_r + CNT_W'(1);
            // Pulse is launched with the last beat so it is visible during COMMIT.
            if (last_beat_s) begin
              state_r <= COMMIT;
              if (tgt_vec_r) begin
                vec_we_o   <= 1'b1;
                vec_dest_o <= vec_dest_r;
                vec_wd_o   <= asm_s;
              end else begin
                int_we_o   <= 1'b1;
                int_dest_o <= int_dest_r;
                int_wd_o   <= asm_s[REGI_SIZE-1:0];
              end
            end
          end
        end
        COMMIT: begin
          state_r <= IDLE;
          ready_o <= 1'b1;
          stall_o <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          ready_o <= 1'b1;
          stall_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
